// File: rtl/ip_uart_rx_inst.sv
// ip_uart_rx_inst: 8N1 UART receiver with a receive FIFO, read by the cZ80 through a DATA and a STAT port.
// Bus outputs stay at zero unless this block is addressed, so they can be OR-combined with other devices.
module ip_uart_rx_inst #(
    parameter int unsigned clk_freq        = 37125000,
    parameter int unsigned uart_freq       = 115200,
    parameter logic [7:0]  io_base         = 8'h10,
    parameter int unsigned fifo_depth_bits = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] bus_address,
    input  logic       bus_ioreq,
    input  logic       bus_write,
    input  logic       bus_valid,
    output logic       bus_ready,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_rdata_en,
    input  logic       uart_rx
);
    localparam int unsigned   DIV       = clk_freq / uart_freq;
    localparam int unsigned   HALF      = DIV / 2;
    localparam int unsigned   CW        = $clog2(DIV);
    localparam int unsigned   PW        = fifo_depth_bits;
    localparam logic [CW-1:0] CNT_BIT   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
    localparam logic [PW:0]   CNT_FULL  = {1'b1, {PW{1'b0}}};
    localparam logic [7:0]    DATA_ADDR = io_base;
    localparam logic [7:0]    STAT_ADDR = io_base + 8'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } rx_state_t;

    rx_state_t     state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          rx_meta, rxs;
    logic          rx_push, rx_ferr;

    logic [7:0]    mem [0:(1 << PW) - 1];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          full, not_empty, do_push, do_pop;
    logic          overrun, frame_err;

    logic          hit, rd_data, rd_stat, wr_stat, flush, clr_err;
    logic [7:0]    rdata_q;
    logic          rdata_en_q;
    logic          unused_wdata;

    assign unused_wdata = ^bus_wdata[7:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shreg   <= shreg_nx;
        end
    end

    // Start bit is re-checked at half a bit so every later sample lands mid-bit.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CW'(1);
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (!rxs) state_nx = ST_START;
            end
            ST_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nx = '0;
                    if (!rxs) begin
                        state_nx   = ST_DATA;
                        bit_idx_nx = '0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt == CNT_BIT) begin
                    cnt_nx            = '0;
                    shreg_nx[bit_idx] = rxs;
                    if (bit_idx == 3'd7) state_nx = ST_STOP;
                    else bit_idx_nx = bit_idx + 3'd1;
                end
            end
            ST_STOP: begin
                if (cnt == CNT_BIT) begin
                    cnt_nx = '0;
                    if (rxs) begin
                        rx_push  = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        rx_ferr  = 1'b1;
                        state_nx = ST_BRK;
                    end
                end
            end
            ST_BRK: begin
                cnt_nx = '0;
                if (rxs) state_nx = ST_IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign hit       = bus_valid & bus_ioreq & ((bus_address == DATA_ADDR) | (bus_address == STAT_ADDR));
    assign bus_ready = hit;
    assign rd_data   = hit & !bus_write & (bus_address == DATA_ADDR);
    assign rd_stat   = hit & !bus_write & (bus_address == STAT_ADDR);
    assign wr_stat   = hit & bus_write & (bus_address == STAT_ADDR);
    assign clr_err   = wr_stat & bus_wdata[0];
    assign flush     = wr_stat & bus_wdata[1];

    assign full      = (count == CNT_FULL);
    assign not_empty = (count != '0);
    assign do_pop    = rd_data & not_empty;
    // A full FIFO still accepts a byte when a pop frees the head slot in the same cycle.
    assign do_push   = rx_push & (!full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Error flags are sticky; a new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_push & !do_push) overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (rx_ferr) frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q    <= 8'h00;
            rdata_en_q <= 1'b0;
        end else begin
            rdata_en_q <= rd_data | rd_stat;
            if (rd_data) rdata_q <= not_empty ? mem[rd_ptr] : 8'h00;
            else if (rd_stat) rdata_q <= {4'b0000, overrun, frame_err, full, not_empty};
            else rdata_q <= 8'h00;
        end
    end

    assign bus_rdata    = rdata_q;
    assign bus_rdata_en = rdata_en_q;

endmodule

// File: tb/tb_ip_uart_rx_inst.sv
// tb_ip_uart_rx_inst: self-checking bench for the UART receiver; received bytes go to a queue
// when each frame is sent and are popped when the CPU-side DATA port returns them.
module tb_ip_uart_rx_inst;
    localparam int         DIV    = 322;
    localparam logic [7:0] DATA_A = 8'h10;
    localparam logic [7:0] STAT_A = 8'h11;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] bus_address = 8'h00;
    logic       bus_ioreq = 1'b0;
    logic       bus_write = 1'b0;
    logic       bus_valid = 1'b0;
    logic       bus_ready;
    logic [7:0] bus_wdata = 8'h00;
    logic [7:0] bus_rdata;
    logic       bus_rdata_en;
    logic       uart_rx = 1'b1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    always #5 clk = ~clk;

    ip_uart_rx_inst dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_address (bus_address),
        .bus_ioreq   (bus_ioreq),
        .bus_write   (bus_write),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_rdata_en(bus_rdata_en),
        .uart_rx     (uart_rx)
    );

    function automatic logic [7:0] model_stat();
        return {4'b0000, m_ovr, m_ferr, exp_q.size() == 16, exp_q.size() != 0};
    endfunction

    task automatic bus_read(input logic [7:0] addr, input logic ioreq,
                            output logic rdy, output logic [7:0] data, output logic en);
        @(negedge clk);
        bus_address = addr;
        bus_ioreq   = ioreq;
        bus_write   = 1'b0;
        bus_valid   = 1'b1;
        #1 rdy = bus_ready;
        @(posedge clk);
        #1;
        bus_valid = 1'b0;
        bus_ioreq = 1'b0;
        data      = bus_rdata;
        en        = bus_rdata_en;
    endtask

    task automatic bus_wr(input logic [7:0] addr, input logic [7:0] data, output logic rdy);
        @(negedge clk);
        bus_address = addr;
        bus_ioreq   = 1'b1;
        bus_write   = 1'b1;
        bus_valid   = 1'b1;
        bus_wdata   = data;
        #1 rdy = bus_ready;
        @(posedge clk);
        #1;
        bus_valid = 1'b0;
        bus_ioreq = 1'b0;
        bus_write = 1'b0;
        bus_wdata = 8'h00;
    endtask

    // Full 8N1 frame; the scoreboard is updated with what the receiver should do with it.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop;
        repeat (DIV) @(negedge clk);
        if (!stop) begin
            uart_rx = 1'b1;
            repeat (DIV) @(negedge clk);
            m_ferr = 1'b1;
        end else if (exp_q.size() < 16) begin
            exp_q.push_back(b);
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic rdy, en;
        logic [7:0] d;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_ready, bus_rdata_en, bus_rdata} !== 10'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %03h expected 000", {bus_ready, bus_rdata_en, bus_rdata});
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(STAT_A, 1'b1, rdy, d, en);
        checks++;
        if ({rdy, en, d} !== {1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset_stat: got rdy=%b en=%b d=%02h expected rdy=1 en=1 d=00", rdy, en, d);
        end
    endtask

    task automatic test_single_byte();
        logic rdy, en;
        logic [7:0] d, exp;
        send_byte(8'hA5, 1'b1);
        bus_read(STAT_A, 1'b1, rdy, d, en);
        exp = model_stat();
        checks++;
        if ({rdy, en, d} !== {1'b1, 1'b1, exp}) begin
            errors++;
            $display("[TB] FAIL single_stat: got rdy=%b en=%b d=%02h expected %02h", rdy, en, d, exp);
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        bus_read(DATA_A, 1'b1, rdy, d, en);
        checks++;
        if ({en, d} !== {1'b1, exp}) begin
            errors++;
            $display("[TB] FAIL single_data: got en=%b d=%02h expected %02h", en, d, exp);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus_rdata_en, bus_rdata} !== 9'h000) begin
            errors++;
            $display("[TB] FAIL strobe_one_cycle: got en=%b d=%02h expected en=0 d=00", bus_rdata_en, bus_rdata);
        end
        bus_read(STAT_A, 1'b1, rdy, d, en);
        exp = model_stat();
        checks++;
        if (d !== exp) begin
            errors++;
            $display("[TB] FAIL single_stat_after: got %02h expected %02h", d, exp);
        end
        bus_read(DATA_A, 1'b1, rdy, d, en);
        checks++;
        if ({en, d} !== {1'b1, 8'h00}) begin
            errors++;
            $display("[TB] FAIL empty_data: got en=%b d=%02h expected en=1 d=00", en, d);
        end
    endtask

    task automatic test_overrun();
        logic rdy, en;
        logic [7:0] d, exp;
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
        bus_read(STAT_A, 1'b1, rdy, d, en);
        exp = model_stat();
        checks++;
        if (d !== exp) begin
            errors++;
            $display("[TB] FAIL overrun_stat: got %02h expected %02h", d, exp);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
            bus_read(DATA_A, 1'b1, rdy, d, en);
            checks++;
            if (d !== exp) begin
                errors++;
                $display("[TB] FAIL overrun_data[%0d]: got %02h expected %02h", i, d, exp);
            end
        end
        bus_read(STAT_A, 1'b1, rdy, d, en);
        exp = model_stat();
        checks++;
        if (d !== exp) begin
            errors++;
            $display("[TB] FAIL overrun_stat_drained: got %02h expected %02h", d, exp);
        end
        bus_wr(STAT_A, 8'h01, rdy);
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        bus_read(STAT_A, 1'b1, rdy, d, en);
        checks++;
        if (d !== model_stat()) begin
            errors++;
            $display("[TB] FAIL overrun_clear: got %02h expected %02h", d, model_stat());
        end
    endtask

    task automatic test_frame_error();
        logic rdy, en;
        logic [7:0] d, exp;
        send_byte(8'h3C, 1'b0);
        bus_read(STAT_A, 1'b1, rdy, d, en);
        exp = model_stat();
        checks++;
        if (d !== exp) begin
            errors++;
            $display("[TB] FAIL frame_err_stat: got %02h expected %02h", d, exp);
        end
        bus_wr(STAT_A, 8'h01, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stat_write_ready: got %b expected 1", rdy);
        end
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        bus_read(STAT_A, 1'b1, rdy, d, en);
        checks++;
        if (d !== model_stat()) begin
            errors++;
            $display("[TB] FAIL frame_err_clear: got %02h expected %02h", d, model_stat());
        end
    endtask

    task automatic test_glitch();
        logic rdy, en;
        logic [7:0] d;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (100) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        bus_read(STAT_A, 1'b1, rdy, d, en);
        checks++;
        if (d !== model_stat()) begin
            errors++;
            $display("[TB] FAIL glitch_stat: got %02h expected %02h", d, model_stat());
        end
    endtask

    // The DATA read is placed in the exact cycle that the stop-bit sample pushes 8'h55.
    task automatic test_push_pop_same_cycle();
        logic rdy, en;
        logic [7:0] d, exp;
        logic [7:0] b;
        b = 8'h55;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (162) @(negedge clk);
        bus_read(DATA_A, 1'b1, rdy, d, en);
        checks++;
        if ({en, d} !== {1'b1, 8'h00}) begin
            errors++;
            $display("[TB] FAIL same_cycle_empty_read: got en=%b d=%02h expected en=1 d=00", en, d);
        end
        exp_q.push_back(b);
        repeat (DIV) @(negedge clk);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        bus_read(DATA_A, 1'b1, rdy, d, en);
        checks++;
        if (d !== exp) begin
            errors++;
            $display("[TB] FAIL same_cycle_next_read: got %02h expected %02h", d, exp);
        end
    endtask

    task automatic test_bus_decode();
        logic rdy, en;
        logic [7:0] d;
        bus_read(8'h12, 1'b1, rdy, d, en);
        checks++;
        if ({rdy, en, d} !== 10'h000) begin
            errors++;
            $display("[TB] FAIL decode_base_plus2: got rdy=%b en=%b d=%02h expected all 0", rdy, en, d);
        end
        bus_read(DATA_A, 1'b0, rdy, d, en);
        checks++;
        if ({rdy, en, d} !== 10'h000) begin
            errors++;
            $display("[TB] FAIL decode_no_ioreq: got rdy=%b en=%b d=%02h expected all 0", rdy, en, d);
        end
        bus_wr(DATA_A, 8'hFF, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL data_write_ready: got %b expected 1", rdy);
        end
        bus_read(STAT_A, 1'b1, rdy, d, en);
        checks++;
        if (d !== model_stat()) begin
            errors++;
            $display("[TB] FAIL data_write_ignored: got %02h expected %02h", d, model_stat());
        end
    endtask

    task automatic test_flush();
        logic rdy, en;
        logic [7:0] d;
        send_byte(8'h77, 1'b1);
        bus_read(STAT_A, 1'b1, rdy, d, en);
        checks++;
        if (d !== model_stat()) begin
            errors++;
            $display("[TB] FAIL flush_before: got %02h expected %02h", d, model_stat());
        end
        bus_wr(STAT_A, 8'h02, rdy);
        exp_q.delete();
        bus_read(STAT_A, 1'b1, rdy, d, en);
        checks++;
        if (d !== model_stat()) begin
            errors++;
            $display("[TB] FAIL flush_stat: got %02h expected %02h", d, model_stat());
        end
        bus_read(DATA_A, 1'b1, rdy, d, en);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("[TB] FAIL flush_data: got %02h expected 00", d);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic rdy, en;
        logic [7:0] d;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus_ready, bus_rdata_en, bus_rdata} !== 10'h000) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got %03h expected 000", {bus_ready, bus_rdata_en, bus_rdata});
        end
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        reset_n = 1'b1;
        exp_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        repeat (12 * DIV) @(negedge clk);
        bus_read(STAT_A, 1'b1, rdy, d, en);
        checks++;
        if (d !== model_stat()) begin
            errors++;
            $display("[TB] FAIL mid_reset_stat: got %02h expected %02h", d, model_stat());
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_push_pop_same_cycle();
        test_bus_decode();
        test_flush();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
